// File: rtl/instr_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder_pkg
// Purpose  : MIPS opcode/funct/class/alucontrol encodings shared by the
//            encoder, its self-checker and the aludec truth table.
// Revision : 1.0 - initial release
// ============================================================================
package instr_encoder_pkg;

    typedef logic [2:0]  cls_t;
    typedef logic [2:0]  alu_t;
    typedef logic [4:0]  reg_t;
    typedef logic [31:0] word_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam cls_t CLS_R    = 3'd0;
    localparam cls_t CLS_LW   = 3'd1;
    localparam cls_t CLS_SW   = 3'd2;
    localparam cls_t CLS_BEQ  = 3'd3;
    localparam cls_t CLS_ADDI = 3'd4;
    localparam cls_t CLS_J    = 3'd5;

    localparam alu_t ALU_ADD = 3'b010;
    localparam alu_t ALU_SUB = 3'b110;
    localparam alu_t ALU_AND = 3'b000;
    localparam alu_t ALU_OR  = 3'b001;
    localparam alu_t ALU_SLT = 3'b111;

    // Returns {legal, funct}; the three unused alucontrol codes are illegal.
    function automatic logic [6:0] alu_funct(input alu_t a);
        case (a)
            ALU_ADD: alu_funct = {1'b1, FUNCT_ADD};
            ALU_SUB: alu_funct = {1'b1, FUNCT_SUB};
            ALU_AND: alu_funct = {1'b1, FUNCT_AND};
            ALU_OR:  alu_funct = {1'b1, FUNCT_OR};
            ALU_SLT: alu_funct = {1'b1, FUNCT_SLT};
            default: alu_funct = {1'b0, 6'b000000};
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_encoder_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder_if
// Purpose  : Field-bundle input and instruction-word output streams.
//            master = bundle producer / word consumer, slave = encoder.
// Revision : 1.0 - initial release
// ============================================================================
interface instr_encoder_if;
    import instr_encoder_pkg::*;

    logic         in_valid;
    logic         in_ready;
    cls_t         cls;
    alu_t         alucontrol;
    reg_t         rs;
    reg_t         rt;
    reg_t         rd;
    logic [15:0]  imm;
    logic [25:0]  target;
    logic         out_valid;
    logic         out_ready;
    word_t        instr;

    modport master (
        output in_valid, cls, alucontrol, rs, rt, rd, imm, target, out_ready,
        input  in_ready, out_valid, instr
    );

    modport slave (
        input  in_valid, cls, alucontrol, rs, rt, rd, imm, target, out_ready,
        output in_ready, out_valid, instr
    );
endinterface
`default_nettype wire

// File: rtl/instr_encoder_word_fifo.sv
`default_nettype none
// ============================================================================
// Module   : word_fifo
// Purpose  : DEPTH-entry, 32-bit output buffer; head word is driven from
//            registered state and reads as zero while empty.
// Revision : 1.0 - initial release
// ============================================================================
module word_fifo
    import instr_encoder_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  wr_en_i,
    input  word_t wr_data_i,
    input  logic  rd_en_i,
    output word_t rd_data_o,
    output logic  full_o,
    output logic  empty_o
);
    localparam int            AW     = $clog2(DEPTH) + 1;
    localparam logic [AW-1:0] c_LAST = AW'(DEPTH - 1);
    localparam logic [AW-1:0] c_FULL = AW'(DEPTH);

    word_t         mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] count_q, count_d;

    assign full_o    = (count_q == c_FULL);
    assign empty_o   = (count_q == '0);
    assign rd_data_o = empty_o ? '0 : mem[rd_ptr_q[AW-2:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en_i) begin
            wr_ptr_d = (wr_ptr_q == c_LAST) ? '0 : wr_ptr_q + AW'(1);
        end
        if (rd_en_i) begin
            rd_ptr_d = (rd_ptr_q == c_LAST) ? '0 : rd_ptr_q + AW'(1);
        end
        case ({wr_en_i, rd_en_i})
            2'b10:   count_d = count_q + AW'(1);
            2'b01:   count_d = count_q - AW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: contents are only observable while count_q != 0.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem[wr_ptr_q[AW-2:0]] <= wr_data_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder
// Purpose  : Encodes decoded MIPS field bundles into 32-bit instruction words
//            through a registered stage and a small output FIFO.
//            Optional macro INSTR_ENC_SELFCHECK_EN adds the chk_fail decoder.
// Revision : 1.0 - initial release
// ============================================================================
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    instr_encoder_if.slave   bus,
    output logic             err,
    output logic [CNT_W-1:0] word_cnt
`ifdef INSTR_ENC_SELFCHECK_EN
    ,
    output logic             chk_fail
`endif
);
    logic             w_rlegal;
    logic [5:0]       w_funct;
    logic             w_legal;
    word_t            w_word;
    logic             w_accept, w_push, w_pop, w_full, w_empty;
    logic             rdy_q;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign {w_rlegal, w_funct} = alu_funct(bus.alucontrol);

    always_comb begin
        w_legal = 1'b1;
        w_word  = '0;
        case (bus.cls)
            CLS_R: begin
                w_word  = {OP_RTYPE, bus.rs, bus.rt, bus.rd, 5'b00000, w_funct};
                w_legal = w_rlegal;
            end
            CLS_LW:   w_word = {OP_LW,   bus.rs, bus.rt, bus.imm};
            CLS_SW:   w_word = {OP_SW,   bus.rs, bus.rt, bus.imm};
            CLS_BEQ:  w_word = {OP_BEQ,  bus.rs, bus.rt, bus.imm};
            CLS_ADDI: w_word = {OP_ADDI, bus.rs, bus.rt, bus.imm};
            CLS_J:    w_word = {OP_J, bus.target};
            default:  w_legal = 1'b0;
        endcase
    end

    // in_ready depends only on registered state, never on out_ready.
    assign bus.in_ready  = rdy_q & ~w_full;
    assign bus.out_valid = ~w_empty;
    assign w_accept      = bus.in_valid & bus.in_ready;
    assign w_push        = w_accept & w_legal;
    assign w_pop         = bus.out_valid & bus.out_ready;
    assign err_d         = w_accept & ~w_legal;
    assign cnt_d         = cnt_q + CNT_W'(w_pop);
    assign err           = err_q;
    assign word_cnt      = cnt_q;

    word_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (w_push),
        .wr_data_i (w_word),
        .rd_en_i   (w_pop),
        .rd_data_o (bus.instr),
        .full_o    (w_full),
        .empty_o   (w_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdy_q <= 1'b0;
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            rdy_q <= 1'b1;
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

`ifdef INSTR_ENC_SELFCHECK_EN
    cls_t w_dec_cls;
    alu_t w_dec_alu;
    logic w_dec_op_ok, w_dec_fn_ok, w_mism;
    logic chk_q;

    always_comb begin
        w_dec_cls   = CLS_R;
        w_dec_alu   = ALU_ADD;
        w_dec_op_ok = 1'b1;
        w_dec_fn_ok = 1'b1;
        case (w_word[31:26])
            OP_RTYPE: w_dec_cls = CLS_R;
            OP_LW:    w_dec_cls = CLS_LW;
            OP_SW:    w_dec_cls = CLS_SW;
            OP_BEQ:   w_dec_cls = CLS_BEQ;
            OP_ADDI:  w_dec_cls = CLS_ADDI;
            OP_J:     w_dec_cls = CLS_J;
            default:  w_dec_op_ok = 1'b0;
        endcase
        case (w_word[5:0])
            FUNCT_ADD: w_dec_alu = ALU_ADD;
            FUNCT_SUB: w_dec_alu = ALU_SUB;
            FUNCT_AND: w_dec_alu = ALU_AND;
            FUNCT_OR:  w_dec_alu = ALU_OR;
            FUNCT_SLT: w_dec_alu = ALU_SLT;
            default:   w_dec_fn_ok = 1'b0;
        endcase
    end

    assign w_mism = ~w_dec_op_ok | (w_dec_cls != bus.cls) |
                    ((bus.cls == CLS_R) & (~w_dec_fn_ok | (w_dec_alu != bus.alucontrol)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chk_q <= 1'b0;
        end else begin
            chk_q <= chk_q | (w_push & w_mism);
        end
    end

    assign chk_fail = chk_q;
`endif

endmodule
`default_nettype wire

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the instruction control decode path: accepts decoded instruction fields and produces 32-bit MIPS instruction words on a streaming interface.
- Used by the test-program generator and the instruction-memory preload path.
- Core-subset encodings: R-type add/sub/and/or/slt, lw, sw, beq, addi, j.
- Registered encode stage, small output FIFO, valid/ready on both sides.

Parameters:
- DEPTH, 2, output FIFO entries (power of two, ≥2)
- CNT_W, 16, width of emitted-word counter

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high
- in_valid  input  1  field bundle valid
- in_ready  output  1  block can accept a bundle this cycle
- cls  input  3  class: 0 R-type, 1 lw, 2 sw, 3 beq, 4 addi, 5 j, 6/7 illegal
- alucontrol  input  3  R-type op: 010 add, 110 sub, 000 and, 001 or, 111 slt
- rs, rt, rd  input  5 each  register fields
- imm  input  16  immediate / branch offset
- target  input  26  jump target field
- out_valid  output  1  instr valid
- out_ready  input  1  consumer accepts instr
- instr  output  32  encoded word, FIFO head
- err  output  1  one-cycle pulse on illegal bundle
- word_cnt  output  CNT_W  words handed off (out_valid & out_ready)

Behaviour:
- Reset (async, active-high): FIFO empty, out_valid=0, instr=0, err=0, word_cnt=0, in_ready=0 while reset is asserted, then 1 on the first clock after release.
- Accept happens when in_valid & in_ready. in_ready = !full. There is no combinational path from out_ready to in_ready.
- Encoding:
  - R-type: {6'b000000, rs, rt, rd, 5'b0, funct}, with funct add 100000, sub 100010, and 100100, or 100101, slt 101010.
  - lw: {100011, rs, rt, imm}. sw: {101011, rs, rt, imm}. beq: {000100, rs, rt, imm}. addi: {001000, rs, rt, imm}.
  - j: {000010, target}.
  - Unused fields are ignored.
- Illegal input is cls 6/7, or R-type with alucontrol 011/100/101. The bundle is still accepted (consumes the handshake), is not written to the FIFO, and err=1 on the following cycle only.
- Latency: a word accepted at edge N is on instr with out_valid=1 after edge N (visible in cycle N+1) if the FIFO was empty.
- instr and out_valid are driven from registered FIFO state only.
- FIFO behaviour:
  - Write pointer, read pointer and count are each sized log2(DEPTH)+1; pointers wrap modulo DEPTH.
  - Simultaneous push and pop: count is unchanged; allowed even when full, because in_ready=0 prevents the push when full.
  - Pop on empty cannot occur, since out_valid=0.
- out_valid holds, and instr stays stable, until out_ready.
- word_cnt increments on each output handshake and wraps to 0 after 2^CNT_W−1.
- Reset mid-stream flushes all FIFO contents immediately; no partial words are emitted.

Optional Feature:
- INSTR_ENC_SELFCHECK_EN defined:
  - An internal decode of each FIFO-written word (same maindec/aludec truth table) recovers class and alucontrol and compares them with the accepted bundle.
  - On mismatch, sticky output chk_fail=1 until reset.
  - Adds port chk_fail output 1.
- Not defined: no chk_fail port and no checker logic.

Decomposition:
- Shared package/include enc_defs.vh holds:
  - Opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J.
  - Funct constants for add/sub/and/or/slt.
  - cls codes and alucontrol codes, shared with aludec.
- Sub-module word_fifo (parameterised DEPTH, width 32) holds the buffer logic.
- Encode logic stays in instr_encoder.

Test Plan:
- R-type add: cls=0, alucontrol=010, rs=1, rt=2, rd=3, out_ready=1 → instr=0x00221820 one cycle after accept, word_cnt=1.
- Memory ops back-to-back: lw rs=1, rt=2, imm=4 then sw rs=0, rt=2, imm=8 → 0x8C220004 then 0xAC020008 in order.
- Branch/jump: beq rs=1, rt=2, imm=0xFFFF → 0x1022FFFF; j target=0x10 → 0x08000010.
- Backpressure: out_ready=0 with 3 bundles offered → in_ready drops after 2 accepts, instr holds 0x00221820. Then release out_ready → all 3 words emitted in order, word_cnt=3.
- Illegal: cls=6 → accepted, err pulses exactly 1 cycle, no out_valid, word_cnt unchanged. Also R-type with alucontrol=011 gives the same response.
- Reset mid-stream: FIFO holds 2 words, assert reset asynchronously → out_valid=0 immediately. After release, the FIFO is empty and word_cnt=0.
